// File: rtl/player_freeze_ctrl.sv
// Blue-player status-effect controller: round-robin freeze-hit arbitration,
// freeze/grace sequencing on the tick timebase, and hit-point tracking.
//
// state  | meaning
// IDLE   | vulnerable; accepts a hit from the round-robin winner
// FROZEN | movement inhibited; counting FREEZE_TICKS
// GRACE  | invulnerable; counting GRACE_TICKS
// DEAD   | hp exhausted; absorbing until rst
module player_freeze_ctrl #(
  parameter int N_SRC        = 4,
  parameter int FREEZE_TICKS = 15,
  parameter int GRACE_TICKS  = 8,
  parameter int HP_INIT      = 3,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [N_SRC-1:0] hit_req,
  output logic [N_SRC-1:0] hit_ack,
  output logic [2:0]       hit_src,
  output logic             frozen,
  output logic             invuln,
  output logic             dead,
  output logic [2:0]       hp,
  output logic [CNT_W-1:0] effect_left
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FROZEN = 2'd1;
  localparam logic [1:0] S_GRACE  = 2'd2;
  localparam logic [1:0] S_DEAD   = 2'd3;

  localparam logic [3:0] N_SRC_4 = 4'(N_SRC);

  logic [1:0]         state;
  logic [2:0]         rr_ptr;
  logic [2*N_SRC-1:0] req_dbl;
  logic [2*N_SRC-1:0] req_rot;
  logic               win_valid;
  logic [2:0]         win_off;
  logic [3:0]         win_sum;
  logic [2:0]         win_idx;
  logic [3:0]         nxt_sum;
  logic [2:0]         nxt_ptr;

  // Rotate the request vector so bit 0 is rr_ptr; the lowest set bit wins.
  always_comb begin
    req_dbl   = {hit_req, hit_req};
    req_rot   = req_dbl >> rr_ptr;
    win_valid = 1'b0;
    win_off   = 3'd0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        win_valid = 1'b1;
        win_off   = 3'(k);
      end
    end
    win_sum = {1'b0, rr_ptr} + {1'b0, win_off};
    if (win_sum >= N_SRC_4) win_sum = win_sum - N_SRC_4;
    win_idx = win_sum[2:0];
    nxt_sum = win_sum + 4'd1;
    if (nxt_sum >= N_SRC_4) nxt_sum = 4'd0;
    nxt_ptr = nxt_sum[2:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      frozen      <= 1'b0;
      invuln      <= 1'b0;
      dead        <= 1'b0;
      hp          <= 3'(HP_INIT);
      hit_ack     <= '0;
      hit_src     <= 3'd0;
      effect_left <= '0;
      rr_ptr      <= 3'd0;
    end else begin
      hit_ack <= '0;
      case (state)
        S_IDLE: begin
          if (win_valid) begin
            hit_ack <= N_SRC'(1) << win_idx;
            hit_src <= win_idx;
            rr_ptr  <= nxt_ptr;
            hp      <= hp - 3'd1;
            frozen  <= 1'b1;
            if (hp == 3'd1) begin
              state       <= S_DEAD;
              dead        <= 1'b1;
              effect_left <= '0;
            end else begin
              state       <= S_FROZEN;
              effect_left <= CNT_W'(FREEZE_TICKS);
            end
          end
        end
        S_FROZEN: begin
          if (tick) begin
            if (effect_left > CNT_W'(1)) begin
              effect_left <= effect_left - CNT_W'(1);
            end else begin
              state       <= S_GRACE;
              frozen      <= 1'b0;
              invuln      <= 1'b1;
              effect_left <= CNT_W'(GRACE_TICKS);
            end
          end
        end
        S_GRACE: begin
          if (tick) begin
            if (effect_left > CNT_W'(1)) begin
              effect_left <= effect_left - CNT_W'(1);
            end else begin
              state       <= S_IDLE;
              invuln      <= 1'b0;
              effect_left <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_player_freeze_ctrl.sv
// Bench for player_freeze_ctrl: directed vector table, corner sequences and
// randomized traffic against an abstract hit/freeze/grace model.
module tb_player_freeze_ctrl;
  localparam int N  = 4;
  localparam int FT = 15;
  localparam int GT = 8;
  localparam int HI = 3;

  logic       clk = 1'b0;
  logic       rst, tick;
  logic [3:0] hit_req;
  logic [3:0] hit_ack;
  logic [2:0] hit_src;
  logic       frozen, invuln, dead;
  logic [2:0] hp;
  logic [3:0] effect_left;
  logic [16:0] dut_out;

  always #5 clk = ~clk;

  player_freeze_ctrl #(.N_SRC(N), .FREEZE_TICKS(FT), .GRACE_TICKS(GT),
                       .HP_INIT(HI), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .tick(tick), .hit_req(hit_req),
    .hit_ack(hit_ack), .hit_src(hit_src), .frozen(frozen), .invuln(invuln),
    .dead(dead), .hp(hp), .effect_left(effect_left)
  );

  assign dut_out = {hit_ack, hit_src, frozen, invuln, dead, hp, effect_left};

  int n_vec = 0;
  int n_bad = 0;

  // Model: remaining freeze ticks, remaining grace ticks, hp, pointer, dead flag.
  int       m_hp, m_ptr, m_frz, m_grc, m_src;
  bit       m_dead;
  logic [3:0] m_ack;

  typedef struct packed {
    logic        r;
    logic        t;
    logic [3:0]  q;
    logic [16:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [16:0] pk(logic [3:0] a, logic [2:0] s, logic f,
                                     logic i, logic d, logic [2:0] h, logic [3:0] e);
    return {a, s, f, i, d, h, e};
  endfunction

  function automatic void add(logic r, logic t, logic [3:0] q, logic [16:0] e);
    vec_t v;
    v.r = r; v.t = t; v.q = q; v.exp = e;
    tbl.push_back(v);
  endfunction

  function automatic void m_step(logic r, logic t, logic [3:0] q);
    int w;
    bit found;
    if (r) begin
      m_hp = HI; m_ptr = 0; m_frz = 0; m_grc = 0; m_src = 0; m_dead = 0; m_ack = 4'd0;
      return;
    end
    m_ack = 4'd0;
    if (m_dead) begin
    end else if (m_frz > 0) begin
      if (t) begin
        m_frz--;
        if (m_frz == 0) m_grc = GT;
      end
    end else if (m_grc > 0) begin
      if (t) m_grc--;
    end else if (q != 0) begin
      found = 0;
      w = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && q[(m_ptr + k) % N]) begin
          found = 1;
          w = (m_ptr + k) % N;
        end
      end
      m_ack = 4'd1 << w;
      m_src = w;
      m_ptr = (w + 1) % N;
      m_hp--;
      if (m_hp == 0) m_dead = 1;
      else m_frz = FT;
    end
  endfunction

  function automatic logic [16:0] m_exp();
    logic f, i;
    int e;
    f = m_dead || (m_frz > 0);
    i = !m_dead && (m_grc > 0);
    e = (m_frz > 0) ? m_frz : m_grc;
    return pk(m_ack, 3'(m_src), f, i, m_dead, 3'(m_hp), 4'(e));
  endfunction

  task automatic check(string name, logic [16:0] got, logic [16:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got ack/src/f/i/d/hp/eff=%h required %h", name, got, exp);
    end
  endtask

  task automatic chk_int(string name, int got, int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic drive(logic r, logic t, logic [3:0] q);
    rst = r; tick = t; hit_req = q;
    @(posedge clk);
    m_step(r, t, q);
    #1;
  endtask

  task automatic step_chk(string name, logic r, logic t, logic [3:0] q);
    drive(r, t, q);
    check(name, dut_out, m_exp());
  endtask

  int srcs[$];
  int acks;

  initial begin
    rst = 1'b1; tick = 1'b0; hit_req = 4'd0;
    m_step(1'b1, 1'b0, 4'd0);
    repeat (2) @(posedge clk);
    #1;

    // Directed table: single hit through freeze and grace, then coincident tick.
    add(1, 0, 4'b0000, pk(4'b0000, 0, 0, 0, 0, 3, 0));
    add(0, 0, 4'b0010, pk(4'b0010, 1, 1, 0, 0, 2, 15));
    add(0, 0, 4'b0000, pk(4'b0000, 1, 1, 0, 0, 2, 15));
    for (int e = 14; e >= 1; e--) add(0, 1, 4'b0000, pk(4'b0000, 1, 1, 0, 0, 2, 4'(e)));
    add(0, 1, 4'b0000, pk(4'b0000, 1, 0, 1, 0, 2, 8));
    for (int e = 7; e >= 1; e--) add(0, 1, 4'b0000, pk(4'b0000, 1, 0, 1, 0, 2, 4'(e)));
    add(0, 1, 4'b0000, pk(4'b0000, 1, 0, 0, 0, 2, 0));
    add(0, 1, 4'b0001, pk(4'b0001, 0, 1, 0, 0, 1, 15));
    add(0, 1, 4'b0100, pk(4'b0000, 0, 1, 0, 0, 1, 14));
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].r, tbl[i].t, tbl[i].q);
      check($sformatf("table[%0d]", i), dut_out, tbl[i].exp);
    end

    // All requesters held: round-robin 0,1,2 then DEAD with no further acks.
    step_chk("rr_reset", 1'b1, 1'b0, 4'd0);
    for (int c = 0; c < 120; c++) begin
      step_chk("rr_held", 1'b0, 1'b1, 4'hf);
      if (hit_ack != 4'd0) srcs.push_back(int'(hit_src));
    end
    chk_int("rr_ack_count", srcs.size(), 3);
    for (int i = 0; i < srcs.size() && i < 3; i++) chk_int($sformatf("rr_src%0d", i), srcs[i], i);
    chk_int("dead_flags", {dead, frozen, hp}, {1'b1, 1'b1, 3'd0});

    // Reset out of DEAD, then requester 3 alone.
    step_chk("dead_rst", 1'b1, 1'b0, 4'd0);
    chk_int("dead_rst_hp", {dead, hp}, {1'b0, 3'd3});
    step_chk("after_dead_hit", 1'b0, 1'b0, 4'b1000);
    chk_int("after_dead_src", {hit_ack, hit_src}, {4'b1000, 3'd3});

    // Reset in GRACE with effect_left=3 and a coincident tick and request.
    step_chk("g_rst0", 1'b1, 1'b0, 4'd0);
    step_chk("g_hit", 1'b0, 1'b0, 4'b0001);
    for (int c = 0; c < FT + 5; c++) step_chk("g_cnt", 1'b0, 1'b1, 4'd0);
    chk_int("g_eff3", {invuln, effect_left}, {1'b1, 4'd3});
    step_chk("g_rst", 1'b1, 1'b1, 4'hf);
    chk_int("g_rst_vals", {hit_ack, frozen, invuln, hp, effect_left},
            {4'd0, 1'b0, 1'b0, 3'd3, 4'd0});
    step_chk("g_ptr", 1'b0, 1'b0, 4'hf);
    chk_int("g_ptr_src", {hit_ack, hit_src}, {4'b0001, 3'd0});

    // Requests dropped in FROZEN without ticks; effect_left holds at 5.
    for (int c = 0; c < 10; c++) step_chk("f_cnt", 1'b0, 1'b1, 4'd0);
    chk_int("f_eff5", effect_left, 5);
    acks = 0;
    for (int c = 0; c < 20; c++) begin
      step_chk("f_hold", 1'b0, 1'b0, 4'b0100);
      if (hit_ack != 4'd0) acks++;
    end
    chk_int("f_hold_state", {acks[3:0], hp, effect_left}, {4'd0, 3'd2, 4'd5});

    // GRACE ends with request held: one IDLE cycle, then accept.
    for (int c = 0; c < 5 + GT - 1; c++) step_chk("e_cnt", 1'b0, 1'b1, 4'b0100);
    chk_int("e_last_grace", {invuln, effect_left}, {1'b1, 4'd1});
    step_chk("e_end", 1'b0, 1'b1, 4'b0100);
    chk_int("e_idle", {hit_ack, frozen, invuln}, {4'd0, 1'b0, 1'b0});
    step_chk("e_accept", 1'b0, 1'b0, 4'b0100);
    chk_int("e_accept_src", {hit_ack, hit_src, hp}, {4'b0100, 3'd2, 3'd1});

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      logic r, t;
      logic [3:0] q;
      r = ($urandom_range(0, 99) == 0);
      t = ($urandom_range(0, 2) == 0);
      q = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      step_chk("random", r, t, q);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/player_freeze_ctrl.md
Name: player_freeze_ctrl

Overview:
Central status-effect controller for the blue player. It arbitrates freeze-hit requests from up to N_SRC slime collision detectors and owns the single player "frozen" resource. It sequences the freeze through a timed state machine: freeze, then an invulnerable grace window, then back to vulnerable. It also tracks player hit points and outputs the frozen, invulnerable and dead flags used by the movement and render logic.

Parameters:
N_SRC, 4, number of collision-detector requesters (1..8)
FREEZE_TICKS, 15, tick strobes the player stays frozen per hit (1..2^CNT_W-1)
GRACE_TICKS, 8, tick strobes of invulnerability after a freeze (1..2^CNT_W-1)
HP_INIT, 3, hit points after reset (1..7)
CNT_W, 4, width of the effect countdown

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
tick  in  1  one-cycle timebase strobe from the ipcnt divider
hit_req  in  N_SRC  per-slime collision level; bit i high = slime i overlaps player contact box
hit_ack  out  N_SRC  one-hot, one-cycle pulse identifying the accepted requester
hit_src  out  3  index of last accepted requester
frozen  out  1  player movement inhibited
invuln  out  1  grace window active; hits ignored
dead  out  1  hp exhausted; latched until rst
hp  out  3  remaining hit points
effect_left  out  CNT_W  ticks remaining in the current FROZEN/GRACE state, else 0

Behaviour:
- Single clock domain. Synchronous active-high rst, applied on the clk edge. All outputs are registered.
- Reset values: state=IDLE, frozen=0, invuln=0, dead=0, hp=HP_INIT, hit_ack=0, hit_src=0, effect_left=0, rr_ptr=0.
- States:
  - IDLE: frozen=0, invuln=0.
  - FROZEN: frozen=1, invuln=0.
  - GRACE: frozen=0, invuln=1.
  - DEAD: frozen=1, dead=1, invuln=0.
- Arbitration (IDLE only):
  - Round-robin starting at rr_ptr. Winner = first set bit of hit_req at or after rr_ptr, wrapping modulo N_SRC.
  - On accept, rr_ptr <= (winner+1) mod N_SRC.
  - hit_req is ignored in FROZEN, GRACE and DEAD. No queuing: requests seen outside IDLE are dropped.
- Accept edge (IDLE, hit_req!=0), latency 1 cycle. On that edge:
  - hit_ack[winner]=1 for exactly one cycle.
  - hit_src=winner.
  - hp<=hp-1. hp never wraps.
  - If the new hp==0: state<=DEAD, effect_left<=0.
  - Otherwise: state<=FROZEN, effect_left<=FREEZE_TICKS.
- A tick coincident with the accept edge is not counted.
- FROZEN and GRACE countdown:
  - On tick with effect_left>1: decrement effect_left.
  - On tick with effect_left==1 in FROZEN: state<=GRACE, effect_left<=GRACE_TICKS.
  - On tick with effect_left==1 in GRACE: state<=IDLE, effect_left<=0.
  - Cycles without tick hold all state.
- Exit from GRACE: if hit_req is still asserted on the edge where GRACE ends, it is not accepted on that edge. It is evaluated on the next cycle in IDLE. Minimum IDLE dwell is 1 cycle.
- DEAD is absorbing. Only rst leaves it. hp stays 0, and no hit_ack is ever issued.
- Reset mid-effect: rst overrides everything in the same cycle, including a simultaneous accept or tick. The next state is the reset values.
- With hit_req held continuously, the hit period is 1 + FREEZE_TICKS + GRACE_TICKS tick-edges plus one IDLE cycle.

Test Plan:
- Reset, then hit_req=4'b0010 for 1 cycle -> next cycle: hit_ack=4'b0010, hit_src=1, frozen=1, hp=2, effect_left=15. Exactly 15 ticks later: frozen=0, invuln=1, effect_left=8. 8 further ticks: IDLE, invuln=0.
- hit_req=4'b1111 held, rr_ptr=0 -> accepted sources in order 0,1,2 over successive hit cycles. The third accept drives hp=0, DEAD, frozen=1, dead=1. No further hit_ack while the request remains held.
- In FROZEN with effect_left=5, assert hit_req=4'b0100 for 20 cycles with no tick -> no hit_ack, hp unchanged, effect_left stays 5.
- tick and hit_req=4'b0001 on the same IDLE edge -> effect_left=15, not 14. GRACE final tick with hit_req held -> IDLE for 1 cycle, then accept.
- rst asserted while in GRACE with effect_left=3 and a tick present -> next cycle: IDLE, hp=3, invuln=0, effect_left=0, rr_ptr=0.
- rst while DEAD -> hp=3, dead=0. A subsequent hit_req=4'b1000 is accepted with hit_src=3.
